// File: rtl/br_resolve.sv
// EX-stage branch resolution and BHT prediction unit.
// Decides taken/not-taken from the comparator flags and funct3, checks the
// prediction carried from IF and issues a registered redirect on mispredict.
// Trains a table of 2-bit saturating counters read by the fetch stage.
module br_resolve #(
  parameter int BHT_DEPTH = 16,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_br_illegal,
  output logic [31:0] o_mispred_cnt
);

  logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
  logic                      redirect_q, redirect_d;
  logic [31:0]               redirect_pc_q, redirect_pc_d;
  logic                      illegal_q, illegal_d;
  logic [31:0]               cnt_q, cnt_d;

  logic             act, br_sel, f3_illegal, br_legal, taken, mispred;
  logic [IDX_W-1:0] ex_idx, if_idx;
  logic [1:0]       ctr;

  // Index bits outside [IDX_W+1:2] of the fetch PC play no part (no tags).
  logic unused_if_pc;
  assign unused_if_pc = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  assign if_idx        = i_if_pc[IDX_W+1:2];
  assign ex_idx        = i_ex_pc[IDX_W+1:2];
  assign o_pred_taken  = bht_q[if_idx][1];
  assign o_br_un       = i_ex_funct3[1];
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_br_illegal  = illegal_q;
  assign o_mispred_cnt = cnt_q;

  // Resolve the EX instruction; the cycle after a redirect is wrong-path.
  always_comb begin
    act        = i_ex_valid & ~redirect_q;
    br_sel     = i_ex_is_br & ~i_ex_is_jmp;
    f3_illegal = (i_ex_funct3[2:1] == 2'b01);
    br_legal   = br_sel & ~f3_illegal;
    taken      = 1'b0;
    case (i_ex_funct3)
      3'b000:         taken = i_br_equal;
      3'b001:         taken = ~i_br_equal;
      3'b100, 3'b110: taken = i_br_less;
      3'b101, 3'b111: taken = ~i_br_less;
      default:        taken = 1'b0;
    endcase
    if (i_ex_is_jmp) taken = 1'b1;
    mispred = act & (br_legal | i_ex_is_jmp) & (taken != i_ex_pred_taken);
  end

  // Next-state for the redirect pulse, corrected PC, illegal flag and counter.
  always_comb begin
    redirect_d    = mispred;
    redirect_pc_d = redirect_pc_q;
    if (mispred) redirect_pc_d = taken ? i_ex_target : i_ex_pc + 32'd4;
    illegal_d     = act & br_sel & f3_illegal;
    cnt_d         = cnt_q + {31'd0, mispred};
  end

  // Saturating counter training on resolved legal conditional branches.
  always_comb begin
    bht_d = bht_q;
    ctr   = bht_q[ex_idx];
    if (act & br_legal) begin
      if (taken && ctr != 2'b11)       bht_d[ex_idx] = ctr + 2'b01;
      else if (!taken && ctr != 2'b00) bht_d[ex_idx] = ctr - 2'b01;
    end
  end

  // State registers; reset forces every counter to weakly not-taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bht_q         <= {BHT_DEPTH{2'b01}};
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
      illegal_q     <= 1'b0;
      cnt_q         <= 32'h0;
    end else begin
      bht_q         <= bht_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
